// File: rtl/sdio_pkg.sv
// rtl/sdio_pkg.sv - shared SDIO card-side types and constants
package sdio_pkg;

  localparam int SDIO_CNT_W = 8;
  localparam logic [SDIO_CNT_W-1:0] SDIO_CNT_MAX = '1;

  typedef enum logic [1:0] {
    CLK_RX_IDLE = 2'd0,
    CLK_RX_WAIT = 2'd1,
    CLK_RX_RUN  = 2'd2
  } clk_rx_state_e;

  function automatic logic [SDIO_CNT_W-1:0] sat_inc(input logic [SDIO_CNT_W-1:0] v);
    return (v == SDIO_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sdio_clk_rx_if.sv
// rtl/sdio_clk_rx_if.sv - SD clock pin, detection controls and recovered strobes/status
interface sdio_clk_rx_if;
  import sdio_pkg::*;

  logic                  clk_i;
  logic                  clk_det_en;
  logic                  tx_pos;
  logic                  rx_neg;
  logic [SDIO_CNT_W-1:0] idle_limit;
  logic                  tx_en;
  logic                  rx_en;
  logic                  clk_level;
  logic                  clk_active;
  logic                  clk_stop;
  logic [SDIO_CNT_W-1:0] half_period;

  modport master (
    output clk_i, clk_det_en, tx_pos, rx_neg, idle_limit,
    input  tx_en, rx_en, clk_level, clk_active, clk_stop, half_period
  );

  modport slave (
    input  clk_i, clk_det_en, tx_pos, rx_neg, idle_limit,
    output tx_en, rx_en, clk_level, clk_active, clk_stop, half_period
  );

endinterface

// File: rtl/sdio_sync.sv
// rtl/sdio_sync.sv - N-stage level synchroniser, async reset to 0, reusable for CMD/DAT pads
module sdio_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             sd_clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [STAGES];

  always_ff @(posedge sd_clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/sdio_clk_rx.sv
// rtl/sdio_clk_rx.sv - card-side SD clock receiver; SDIO_CLK_MEAS_EN enables half-period measurement
module sdio_clk_rx
  import sdio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input logic          sd_clk,
  input logic          rstn,
  sdio_clk_rx_if.slave bus
);

  logic                  sync_lvl;
  logic                  prev;
  logic                  rise;
  logic                  fall;
  logic                  clk_edge;
  logic                  en;
  logic                  stop_cond;
  logic                  tx_q;
  logic                  rx_q;
  logic                  stop_q;
  logic [SDIO_CNT_W-1:0] cnt;
  clk_rx_state_e         state;
  clk_rx_state_e         state_nxt;

  sdio_sync #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync (
    .sd_clk (sd_clk),
    .rstn   (rstn),
    .d      (bus.clk_i),
    .q      (sync_lvl)
  );

  always_ff @(posedge sd_clk or negedge rstn) begin
    if (!rstn) prev <= 1'b0;
    else       prev <= sync_lvl;
  end

  assign rise     = sync_lvl & ~prev;
  assign fall     = ~sync_lvl & prev;
  assign clk_edge = rise | fall;
  assign en       = bus.clk_det_en;

  // A coincident edge beats the timeout, so a half-period equal to idle_limit never stops.
  assign stop_cond = (state == CLK_RX_RUN) && (bus.idle_limit != '0) &&
                     !clk_edge && (cnt == bus.idle_limit);

  always_ff @(posedge sd_clk or negedge rstn) begin
    if (!rstn) state <= CLK_RX_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLK_RX_IDLE: state_nxt = CLK_RX_WAIT;
      CLK_RX_WAIT: if (clk_edge) state_nxt = CLK_RX_RUN;
      CLK_RX_RUN:  if (stop_cond) state_nxt = CLK_RX_WAIT;
      default:     state_nxt = CLK_RX_IDLE;
    endcase
    if (!en) state_nxt = CLK_RX_IDLE;
  end

  always_ff @(posedge sd_clk or negedge rstn) begin
    if (!rstn) begin
      tx_q   <= 1'b0;
      rx_q   <= 1'b0;
      stop_q <= 1'b0;
      cnt    <= '0;
    end else begin
      tx_q   <= en & (bus.tx_pos ? rise : fall);
      rx_q   <= en & (bus.rx_neg ? fall : rise);
      stop_q <= en & stop_cond;
      if (!en)           cnt <= '0;
      else if (clk_edge) cnt <= SDIO_CNT_W'(1);
      else               cnt <= sat_inc(cnt);
    end
  end

  assign bus.tx_en      = tx_q;
  assign bus.rx_en      = rx_q;
  assign bus.clk_stop   = stop_q;
  assign bus.clk_level  = sync_lvl;
  assign bus.clk_active = (state == CLK_RX_RUN);

`ifdef SDIO_CLK_MEAS_EN
  logic [SDIO_CNT_W-1:0] half_q;

  // The first edge out of WAIT only re-arms; its spacing spans the stopped interval.
  always_ff @(posedge sd_clk or negedge rstn) begin
    if (!rstn)                                 half_q <= '0;
    else if (!en)                              half_q <= '0;
    else if (clk_edge && state == CLK_RX_RUN)  half_q <= cnt;
  end

  assign bus.half_period = half_q;
`else
  assign bus.half_period = '0;
`endif

endmodule

// File: tb/tb_sdio_clk_rx.sv
// tb/tb_sdio_clk_rx.sv - scoreboard bench for sdio_clk_rx with an edge-timeline reference model
module tb_sdio_clk_rx;
  import sdio_pkg::*;

  localparam int S = 2;
`ifdef SDIO_CLK_MEAS_EN
  localparam bit MEAS = 1'b1;
`else
  localparam bit MEAS = 1'b0;
`endif

  logic sd_clk = 1'b0;
  logic rstn   = 1'b0;

  sdio_clk_rx_if bus();

  sdio_clk_rx #(.SYNC_STAGES(S)) dut (
    .sd_clk (sd_clk),
    .rstn   (rstn),
    .bus    (bus)
  );

  always #5 sd_clk = ~sd_clk;

  typedef struct {
    int cyc;
    bit tx;
    bit rx;
    bit stop;
    int hp;
  } exp_t;

  exp_t exp_q[$];
  int   gap_q[$];
  bit   pin_hist[int];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   settle = 0;

  // Reference model: everything is expressed as "strobe cycle" of each pin edge.
  int en_until;
  int last_s;
  int hp_m;
  bit running;
  int lim;
  bit cur_tp;
  bit cur_rn;

  always @(posedge sd_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    vectors++;
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp_v);
    end
  endtask

  always @(negedge sd_clk) begin
    exp_t e;
    pin_hist[cyc] = bus.clk_i;
    if (!rstn) begin
      settle = 0;
    end else begin
      if (settle >= S && pin_hist.exists(cyc - S))
        check("clk_level", bus.clk_level, pin_hist[cyc - S]);
      settle++;
      if (bus.tx_en || bus.rx_en || bus.clk_stop) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {bus.tx_en, bus.rx_en, bus.clk_stop}, 0);
        end else begin
          e = exp_q.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("tx_en", bus.tx_en, e.tx);
          check("rx_en", bus.rx_en, e.rx);
          check("clk_stop", bus.clk_stop, e.stop);
          check("half_period", bus.half_period, MEAS ? e.hp : 0);
          check("clk_active", bus.clk_active, !e.stop);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        check("event_present", 1'b0, 1'b1);
      end
    end
  end

  // Called #1 after a posedge: toggles the pin, predicts its outcome, then waits g cycles.
  task automatic pin_edge(input int g, input bit last);
    int s;
    bit rise, tx, rx;
    s = cyc + S + 1;
    rise = !bus.clk_i;
    if (last) en_until = cyc + g;
    bus.clk_i = rise;
    if (s <= en_until) begin
      if (running && last_s >= 0) hp_m = (s - last_s > 255) ? 255 : s - last_s;
      running = 1'b1;
      last_s  = s;
      tx = rise ? cur_tp : !cur_tp;
      rx = rise ? !cur_rn : cur_rn;
      if (tx || rx) exp_q.push_back('{s, tx, rx, 1'b0, hp_m});
      if (lim != 0 && g > lim && s + lim <= en_until) begin
        exp_q.push_back('{s + lim, 1'b0, 1'b0, 1'b1, hp_m});
        running = 1'b0;
      end
    end
    repeat (g) @(posedge sd_clk);
    #1;
  endtask

  task automatic setup_enable(input bit tp, input bit rn, input int l);
    bus.clk_det_en = 1'b0;
    cur_tp = tp;
    cur_rn = rn;
    lim    = l;
    bus.tx_pos     = tp;
    bus.rx_neg     = rn;
    bus.idle_limit = 8'(l);
    repeat (S + 3) @(posedge sd_clk);
    #1;
    bus.clk_det_en = 1'b1;
    en_until = 1 << 30;
    running  = 1'b0;
    last_s   = -1;
    hp_m     = 0;
    repeat (4) @(posedge sd_clk);
    #1;
  endtask

  task automatic drive_and_drop(input int post_toggles);
    int g;
    while (gap_q.size() != 0) begin
      g = gap_q.pop_front();
      pin_edge(g, gap_q.size() == 0);
    end
    bus.clk_det_en = 1'b0;
    running = 1'b0;
    last_s  = -1;
    hp_m    = 0;
    @(posedge sd_clk);
    @(negedge sd_clk);
    check("active_after_drop", bus.clk_active, 0);
    check("hp_after_drop", bus.half_period, 0);
    for (int i = 0; i < post_toggles; i++) begin
      @(posedge sd_clk);
      #1;
      bus.clk_i = !bus.clk_i;
      repeat (3) @(posedge sd_clk);
    end
    repeat (S + 4) @(posedge sd_clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic push_gaps(input int n, input int g, input int last_g);
    for (int i = 0; i < n; i++) gap_q.push_back(g);
    gap_q.push_back(last_g);
  endtask

  initial begin
    int l, n;
    bus.clk_i      = 1'b0;
    bus.clk_det_en = 1'b0;
    bus.tx_pos     = 1'b0;
    bus.rx_neg     = 1'b0;
    bus.idle_limit = '0;
    #12;
    check("reset_outputs", {bus.tx_en, bus.rx_en, bus.clk_level, bus.clk_active,
                            bus.clk_stop, bus.half_period}, 0);
    @(posedge sd_clk);
    #1;
    rstn = 1'b1;

    // half-period 4, default polarities
    setup_enable(1'b0, 1'b0, 0);
    push_gaps(12, 4, 8);
    drive_and_drop(0);

    // idle timeout 10, stop then restart with half_period held
    setup_enable(1'b0, 1'b0, 10);
    gap_q = '{4, 4, 4, 4, 30, 4, 4, 20};
    drive_and_drop(0);

    // edge coincides with cnt == idle_limit
    setup_enable(1'b0, 1'b0, 4);
    push_gaps(10, 4, 3);
    drive_and_drop(0);

    // swapped polarities
    setup_enable(1'b1, 1'b1, 0);
    gap_q = '{3, 5, 4, 6, 2, 7, 4, 10};
    drive_and_drop(0);

    // counter saturation without timeout
    setup_enable(1'b0, 1'b1, 0);
    gap_q = '{4, 300, 4, 4, 6};
    drive_and_drop(0);

    // clk_det_en drops together with an edge, pin keeps toggling
    setup_enable(1'b0, 1'b0, 0);
    push_gaps(6, 4, 2);
    drive_and_drop(4);

    // reset mid-RUN, then restart from a low pin
    setup_enable(1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) pin_edge(4, 1'b0);
    #2;
    rstn = 1'b0;
    bus.clk_i = 1'b0;
    #1;
    check("reset_mid_run", {bus.tx_en, bus.rx_en, bus.clk_level, bus.clk_active,
                            bus.clk_stop, bus.half_period}, 0);
    exp_q.delete();
    repeat (3) @(posedge sd_clk);
    #1;
    running = 1'b0;
    last_s  = -1;
    hp_m    = 0;
    rstn = 1'b1;
    repeat (4) @(posedge sd_clk);
    #1;
    push_gaps(6, 5, 6);
    drive_and_drop(0);

    // randomized segments
    for (int seg = 0; seg < 8; seg++) begin
      l = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 20));
      setup_enable(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), l);
      n = $urandom_range(8, 20);
      for (int i = 0; i < n; i++)
        gap_q.push_back(($urandom_range(0, 5) == 0) ? int'($urandom_range(20, 300))
                                                     : int'($urandom_range(2, 12)));
      gap_q.push_back($urandom_range(2, 40));
      drive_and_drop($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdio_clk_rx.md
# sdio_clk_rx

Card-side SD clock receiver: recovers the host-driven SD clock pin by oversampling it with the local `sd_clk`. It produces one-cycle tx/rx edge strobes for the card's command and data shifters, detects clock start and stop, and measures the host clock half-period. It is the far-end counterpart of the host clock generator and sits between the card's CMD/DAT pads and its line state machines.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth on `clk_i`; legal values are 2 or more.

Ports:
- `sd_clk`  in  1  local oversampling clock; all logic is on its rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `clk_i`  in  1  SD clock pin from the host; asynchronous to `sd_clk`.
- `clk_det_en`  in  1  detection enable; 0 forces the IDLE state.
- `tx_pos`  in  1  1 = tx strobe on rising edges of `clk_i`; 0 = tx strobe on falling edges (spec default).
- `rx_neg`  in  1  1 = rx strobe on falling edges; 0 = rx strobe on rising edges (spec default).
- `idle_limit`  in  8  `sd_clk` cycles without an edge before the clock is declared stopped; 0 disables the timeout.
- `tx_en`  out  1  one-cycle tx strobe.
- `rx_en`  out  1  one-cycle rx strobe.
- `clk_level`  out  1  synchronised `clk_i` level.
- `clk_active`  out  1  high while in the RUN state.
- `clk_stop`  out  1  one-cycle pulse on the RUN->WAIT transition.
- `half_period`  out  8  last measured edge-to-edge spacing in `sd_clk` cycles; saturates at 255.

## Operation
- Synchroniser:
  - `SYNC_STAGES` flops followed by a `prev` flop.
  - rise = sync & ~prev; fall = ~sync & prev; edge = rise | fall.
- Strobes are registered:
  - `tx_en` <= en & (`tx_pos` ? rise : fall).
  - `rx_en` <= en & (`rx_neg` ? fall : rise).
  - Strobes are generated in every state while `clk_det_en`=1, including the first edge in WAIT.
- Cycle counter `cnt` (8 bits, saturating at 255):
  - On an edge, `cnt` is set to 1.
  - Otherwise it increments each cycle while `clk_det_en`=1.
  - It is cleared to 0 when `clk_det_en`=0.
- FSM states and transitions:
  - IDLE -> WAIT when `clk_det_en`=1.
  - WAIT -> RUN on an edge.
  - RUN -> WAIT when `idle_limit`!=0, no edge this cycle, and `cnt`==`idle_limit`. `clk_stop` is 1 in the following cycle.
  - Any state -> IDLE when `clk_det_en`=0. No `clk_stop` pulse is generated on this transition.
- Period measurement: on an edge while in RUN, `half_period` <= `cnt`. The first edge after WAIT does not update `half_period`.
- Boundary conditions:
  - An edge in the same cycle as `cnt`==`idle_limit` wins: the FSM stays in RUN and there is no `clk_stop`.
  - `cnt` saturation with `idle_limit`=0: the FSM stays in RUN and `half_period` saturates at 255 on the next edge.
  - `clk_det_en` falling in the same cycle as an edge: the strobe is suppressed.
  - `clk_det_en`=0 clears `half_period` to 0.
- Reset, asynchronous and valid mid-operation:
  - Synchroniser, `prev`, and `cnt` go to 0.
  - FSM goes to IDLE.
  - All outputs go to 0.

## Timing
- `clk_i` transition -> `clk_level` change: `SYNC_STAGES` cycles.
- `clk_i` transition -> `tx_en`/`rx_en` strobe: `SYNC_STAGES`+1 cycles.
- Each strobe is exactly 1 cycle wide, with at most one strobe of each kind per `clk_i` edge.
- Last edge -> `clk_stop` pulse: `idle_limit`+1 cycles after the edge is detected. `clk_active` falls in the same cycle as the pulse.
- `clk_i` half-period requirement: at least 2 `sd_clk` cycles.
  - Shorter pulses may be missed.
  - The FSM must never lock up; any detected edge re-enters RUN.
- `half_period` updates in the cycle after the edge is detected, the same cycle as the strobe.

## Configuration
- `SDIO_CLK_MEAS_EN` defined: the `half_period` register and its update logic are present as described above.
- `SDIO_CLK_MEAS_EN` undefined:
  - `half_period` is tied to 0.
  - `cnt` is still present for the idle timeout.
  - All other behaviour is identical.

## Structure
- Shared package `sdio_pkg`:
  - FSM encoding `CLK_RX_IDLE`=2'd0, `CLK_RX_WAIT`=2'd1, `CLK_RX_RUN`=2'd2.
  - `SDIO_CNT_W`=8.
- One sub-module, `sdio_sync`: parameterised N-stage level synchroniser with asynchronous reset to 0. It is reusable for the CMD/DAT pad inputs.

## Test plan
- Host clock with half-period 4, `tx_pos`=0, `rx_neg`=0 -> `rx_en` on each rising edge and `tx_en` on each falling edge, each 3 cycles after the pin edge. `half_period`=4 from the second edge onward.
- `idle_limit`=10, clock stops high -> `clk_stop` pulses 11 cycles after the last edge, `clk_active` goes to 0, and the FSM is in WAIT. A new edge -> `clk_active`=1 with `half_period` unchanged.
- `idle_limit`=4 with half-period exactly 4 (edge coincides with `cnt`==4) -> never stops and no `clk_stop`.
- `tx_pos`=1, `rx_neg`=1 -> strobe polarities swap.
- `clk_det_en` dropped mid-clock -> no strobes, no `clk_stop`, `half_period`=0, and `clk_active`=0 the next cycle.
- `rstn` asserted mid-RUN -> all outputs 0 immediately. After release with the clock running, the first `rx_en` appears `SYNC_STAGES`+1 cycles after the first rising edge.
